// File: rtl/jt053244_draw.sv
// jt053244_draw
// Sprite tile row drawer. One dr_start fetches a 16-pixel tile row as two
// 32-bit ROM words, steps through it with a horizontal zoom accumulator and
// writes the opaque pixels into the object line buffer, one pixel per clock.
module jt053244_draw #(
  parameter int HZ_UNITY = 64,   // hzoom for 1:1, 6 fractional bits
  parameter int PXL_MAX  = 511   // hard cap on pixels emitted per tile
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [6:0]  attr,
  input  logic        shd,
  input  logic        hflip,
  input  logic [9:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [11:0] hzoom,
  input  logic        hz_keep,

  output logic        rom_cs,
  output logic [20:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,

  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [11:0] buf_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    DRAW   = 2'd3
  } state_t;

  // Accumulator value that marks the end of the 16 source pixels
  localparam logic [12:0] ACC_END = 13'(16 * HZ_UNITY);
  localparam logic [8:0]  CNT_LAST = 9'(PXL_MAX - 1);

  state_t      st, st_nx;

  // Per-tile latched request
  logic [15:0] code_l;
  logic [6:0]  attr_l;
  logic        shd_l;
  logic        hflip_l;
  logic [3:0]  ysub_l;
  logic [11:0] hz_l;

  // Drawing state; x and carry survive between tiles for hz_keep chaining
  logic [9:0]  x;
  logic [12:0] acc;
  logic [9:0]  carry;
  logic [8:0]  cnt;
  logic [31:0] half0, half1;

  // ROM handshake: cs_r is the registered chip select, arm goes high one
  // clock after a new address is presented so a leftover rom_ok is ignored
  logic        cs_r;
  logic        arm;
  logic        rom_take;

  // Pixel decode and stepping
  logic [3:0]  src;
  logic [31:0] word;
  logic [2:0]  bit_i;
  logic [3:0]  pix;
  logic [11:0] hz_eff;
  logic [12:0] acc_nx;
  logic        draw_end;
  logic        pix_vis;

  assign rom_take = rom_ok & arm;

  // Source pixel selection, bitplane gather and accumulator step
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    src      = hflip_l ? ~acc[9:6] : acc[9:6];   // ~s == 15-s on 4 bits
    word     = src[3] ? half1 : half0;
    bit_i    = src[2:0];
    // Bits 31-i, 23-i, 15-i, 7-i: each plane byte holds one bit per pixel
    pix      = {word[{2'b11, ~bit_i}], word[{2'b10, ~bit_i}],
                word[{2'b01, ~bit_i}], word[{2'b00, ~bit_i}]};
    hz_eff   = (hz_l == 12'd0) ? 12'd1 : hz_l;
    acc_nx   = acc + {1'b0, hz_eff};
    draw_end = (acc_nx >= ACC_END) || (cnt == CNT_LAST);
    pix_vis  = (pix != 4'd0) && !x[9];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of block order.
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // FSM next-state logic
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (dr_start) st_nx = FETCH0;
      FETCH0:  if (rom_take) st_nx = FETCH1;
      FETCH1:  if (rom_take) st_nx = DRAW;
      DRAW:    if (draw_end) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Request latch, ROM capture and per-pixel x/accumulator stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_l  <= '0;
      attr_l  <= '0;
      shd_l   <= 1'b0;
      hflip_l <= 1'b0;
      ysub_l  <= '0;
      hz_l    <= '0;
      x       <= '0;
      acc     <= '0;
      carry   <= '0;
      cnt     <= '0;
      half0   <= '0;
      half1   <= '0;
      cs_r    <= 1'b0;
      arm     <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (dr_start) begin
            code_l  <= code;
            attr_l  <= attr;
            shd_l   <= shd;
            hflip_l <= hflip;
            ysub_l  <= ysub;
            hz_l    <= hzoom;
            cnt     <= '0;
            cs_r    <= 1'b1;
            arm     <= 1'b0;
            if (hz_keep) begin
              acc <= {3'b000, carry};   // x already holds the previous x_end
            end else begin
              x   <= hpos;
              acc <= '0;
            end
          end
        end
        FETCH0: begin
          if (rom_take) begin
            half0 <= rom_data;
            arm   <= 1'b0;              // address changes to the second half
          end else begin
            arm   <= 1'b1;
          end
        end
        FETCH1: begin
          if (rom_take) begin
            half1 <= rom_data;
            arm   <= 1'b0;
            cs_r  <= 1'b0;
          end else begin
            arm   <= 1'b1;
          end
        end
        DRAW: begin
          x   <= x + 10'd1;             // wraps so off-left tiles re-enter
          acc <= acc_nx;
          cnt <= cnt + 9'd1;
          if (draw_end) carry <= 10'(acc_nx - ACC_END);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so a reset clears them without waiting a clock
  always_comb begin
    dr_busy  = (st != IDLE);
    rom_cs   = cs_r;
    rom_addr = cs_r ? {code_l, ysub_l, st == FETCH1} : 21'd0;
    buf_we   = (st == DRAW) && pix_vis;
    buf_addr = buf_we ? x[8:0] : 9'd0;
    buf_din  = buf_we ? {shd_l, attr_l, pix} : 12'd0;
  end

endmodule

// File: tb/tb_jt053244_draw.sv
// Testbench for jt053244_draw: a ROM model with programmable delay and a
// stale-ok glitch, a line-buffer write monitor, and a behavioural tile model.
module tb_jt053244_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] code;
  logic [6:0]  attr;
  logic        shd;
  logic        hflip;
  logic [9:0]  hpos;
  logic [3:0]  ysub;
  logic [11:0] hzoom;
  logic        hz_keep;
  logic        rom_cs;
  logic [20:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [11:0] buf_din;

  int vectors = 0;
  int miscompares = 0;

  jt053244_draw dut (
    .clk(clk), .rst(rst),
    .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .shd(shd), .hflip(hflip), .hpos(hpos),
    .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
  );

  always #5 clk = ~clk;

  // ROM model: answers rom_delay clocks after a stable address; in stale
  // mode it also flashes a bogus rom_ok on the first clock of each address.
  logic [31:0] t_h0, t_h1;
  logic [15:0] t_code;
  logic [3:0]  t_ysub;
  int          rom_delay = 0;
  bit          stale_mode = 0;
  logic [20:0] last_addr = '0;
  logic        last_cs = 1'b0;
  int          rcnt = 0;
  logic        same;

  always @(posedge clk) begin
    last_addr <= rom_addr;
    last_cs   <= rom_cs;
    rcnt      <= (rom_cs && last_cs && rom_addr == last_addr) ? rcnt + 1 : 0;
  end

  always_comb begin
    same     = rom_cs && last_cs && (rom_addr == last_addr);
    rom_ok   = 1'b0;
    rom_data = 32'h0;
    if (rom_cs && !same && stale_mode) begin
      rom_ok   = 1'b1;
      rom_data = 32'h5A5A_C3C3;
    end else if (same && (rcnt + 1 >= rom_delay)) begin
      rom_ok   = 1'b1;
      rom_data = (rom_addr[20:1] == {t_code, t_ysub}) ?
                 (rom_addr[0] ? t_h1 : t_h0) : 32'h9696_6969;
    end
  end

  // Line-buffer monitor, sampled away from the active edge
  int wq[$];
  int busy_cyc = 0;
  always @(negedge clk) begin
    if (buf_we)  wq.push_back(int'({buf_addr, buf_din}));
    if (dr_busy) busy_cyc++;
  end

  // Behavioural model: walk the 16 source pixels with a fractional step
  int         eq[$];
  logic [9:0] mx = '0;
  logic [9:0] mcarry = '0;

  task automatic model_draw(input logic s_, input logic [6:0] a, input logic hf,
                            input logic [9:0] hp, input logic [11:0] hz,
                            input logic keep, input logic [31:0] w0,
                            input logic [31:0] w1, output int npx);
    logic [9:0]  xm;
    logic [31:0] wd;
    logic [3:0]  p;
    int acc, hzv, s, i;
    xm  = keep ? mx : hp;
    acc = keep ? int'(mcarry) : 0;
    hzv = (hz == 0) ? 1 : int'(hz);
    npx = 0;
    eq.delete();
    do begin
      s = (acc / 64) % 16;
      if (hf) s = 15 - s;
      wd = (s >= 8) ? w1 : w0;
      i  = s % 8;
      p  = {wd[31-i], wd[23-i], wd[15-i], wd[7-i]};
      if (p != 0 && xm < 10'd512) eq.push_back(int'({xm[8:0], s_, a, p}));
      xm  = xm + 10'd1;
      acc = acc + hzv;
      npx++;
    end while (acc < 1024 && npx < 511);
    mcarry = 10'(acc - 1024);
    mx     = xm;
  endtask

  // One complete tile: drive, wait for completion, compare writes and timing
  task automatic run_draw(input string name, input logic [15:0] c,
                          input logic [6:0] a, input logic s_, input logic hf,
                          input logic [9:0] hp, input logic [3:0] ys,
                          input logic [11:0] hz, input logic keep,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int dly, input bit stl);
    int npx, t, exp_busy, n;
    t_h0 = w0; t_h1 = w1; t_code = c; t_ysub = ys;
    rom_delay = dly; stale_mode = stl;
    model_draw(s_, a, hf, hp, hz, keep, w0, w1, npx);
    @(negedge clk);
    wq.delete();
    busy_cyc = 0;
    code = c; attr = a; shd = s_; hflip = hf; hpos = hp; ysub = ys;
    hzoom = hz; hz_keep = keep; dr_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dr_start = 1'b0;
    // Scramble request inputs: the draw must use the latched copies
    code = 16'($urandom); attr = 7'($urandom); hpos = 10'($urandom);
    ysub = 4'($urandom); hzoom = 12'($urandom); hflip = ~hf; hz_keep = ~keep;
    t = 0;
    while (dr_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 3000) begin
      miscompares++;
      $display("FAIL %s timeout: busy still %0b after %0d clk, required 0", name, dr_busy, t);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (dr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s restart: busy %0b after end, required 0", name, dr_busy);
    end
    exp_busy = 2 * (1 + ((dly > 1) ? dly : 1)) + npx;
    vectors++;
    if (busy_cyc != exp_busy) begin
      miscompares++;
      $display("FAIL %s busy_len: got %0d clk, required %0d", name, busy_cyc, exp_busy);
    end
    vectors++;
    if (wq.size() != eq.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), eq.size());
    end
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (wq[k] != eq[k]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: got addr %0h din %0h, required addr %0h din %0h",
                 name, k, wq[k] >> 12, wq[k] & 'hFFF, eq[k] >> 12, eq[k] & 'hFFF);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dr_start = 1'b0; code = '0; attr = '0; shd = 1'b0; hflip = 1'b0;
    hpos = '0; ysub = '0; hzoom = '0; hz_keep = 1'b0;
    t_h0 = '0; t_h1 = '0; t_code = '0; t_ysub = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dr_busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy %0b cs %0b addr %0h we %0b badr %0h din %0h, required all 0",
               dr_busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din);
    end
    rst = 1'b0;
    mx = '0; mcarry = '0;
    @(negedge clk);
  endtask

  task automatic test_unity;
    run_draw("unity", 16'h1234, 7'h55, 1'b0, 1'b0, 10'h020, 4'h3, 12'h040, 1'b0,
             32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0);
    run_draw("unity_hflip", 16'h1234, 7'h2A, 1'b1, 1'b1, 10'h020, 4'h3, 12'h040, 1'b0,
             32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0);
  endtask

  task automatic test_zoom;
    run_draw("shrink", 16'hBEEF, 7'h11, 1'b0, 1'b0, 10'h020, 4'h9, 12'h080, 1'b0,
             32'h1357_9BDF, 32'h2468_ACE0, 1, 0);
    run_draw("enlarge", 16'h0F0F, 7'h7F, 1'b0, 1'b0, 10'h020, 4'hF, 12'h020, 1'b0,
             32'hFFFF_FFFF, 32'hA5A5_5A5A, 0, 0);
    run_draw("keep_chain", 16'h0F10, 7'h01, 1'b1, 1'b0, 10'h1F0, 4'hF, 12'h040, 1'b1,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    vectors++;
    if (eq.size() == 0 || wq.size() == 0 || (wq[0] >> 12) != 'h040) begin
      miscompares++;
      $display("FAIL keep_chain_start: got first x %0h, required 40",
               (wq.size() != 0) ? (wq[0] >> 12) : -1);
    end
    run_draw("zoom_zero", 16'h4321, 7'h3C, 1'b0, 1'b0, 10'h000, 4'h0, 12'h000, 1'b0,
             32'hF0F0_0F0F, 32'h1111_8888, 0, 0);
  endtask

  task automatic test_wrap_stale;
    run_draw("wrap_stale", 16'h8001, 7'h40, 1'b0, 1'b0, 10'h3FC, 4'h7, 12'h040, 1'b0,
             32'hFFFF_FFFF, 32'h00FF_00FF, 5, 1);
  endtask

  task automatic test_reset_mid;
    int t;
    t_h0 = 32'hFFFF_FFFF; t_h1 = 32'hFFFF_FFFF; t_code = 16'h0777; t_ysub = 4'h2;
    rom_delay = 0; stale_mode = 0;
    @(negedge clk);
    wq.delete();
    code = 16'h0777; attr = 7'h22; shd = 1'b0; hflip = 1'b0; hpos = 10'h100;
    ysub = 4'h2; hzoom = 12'h020; hz_keep = 1'b0; dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    t = 0;
    while (wq.size() < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL reset_mid_reach: got %0d writes, required 3", wq.size());
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({dr_busy, buf_we, rom_cs} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got busy %0b we %0b cs %0b, required 0 0 0",
               dr_busy, buf_we, rom_cs);
    end
    @(negedge clk);
    rst = 1'b0;
    mx = '0; mcarry = '0;
    run_draw("after_reset", 16'h0777, 7'h22, 1'b0, 1'b0, 10'h155, 4'h2, 12'h040, 1'b1,
             32'hFFFF_FFFF, 32'h0F0F_0F0F, 0, 0);
  endtask

  task automatic test_random;
    logic [11:0] hz;
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0:       hz = 12'($urandom_range(16, 63));
        1:       hz = 12'($urandom_range(64, 400));
        2:       hz = 12'($urandom_range(401, 4095));
        default: hz = 12'h040;
      endcase
      run_draw("random", 16'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
               10'($urandom), 4'($urandom), hz, 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom_range(0, 6), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_zoom();
    test_wrap_stale();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
